// File: rtl/bidin_pp.sv
// Ping-pong block deinterleaver: two N-word banks filled row-major, read back
// column-major (mode 0) or linearly (mode 1) on decoder request.
module bidin_pp #(
  parameter int unsigned WID  = 6,
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 12
) (
  input  logic           clk6,
  input  logic           rst,
  input  logic           bidin_sync_in,
  input  logic           bidin_ena_in,
  input  logic [WID-1:0] bidin_din,
  input  logic           bidin_mode,
  input  logic           ldpc_req,
  input  logic           ldpc_fin,
  output logic           bidin_rdy,
  output logic           bidin_full,
  output logic           bidin_ovf,
  output logic           bidin_ena_out,
  output logic [WID-1:0] bidin_dout
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

  typedef enum logic {W_IDLE, W_FILL} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DONE} r_state_e;

  logic [WID-1:0] mem_q [2][N];

  w_state_e       w_state_q, w_state_d;
  logic           wb_q, wb_d;
  logic [AW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]     full_q, full_d;
  logic           ovf_q, ovf_d;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [1:0]     set_full, clr_full;

  r_state_e       r_state_q, r_state_d;
  logic           rb_q, rb_d;
  logic           mode_q, mode_d;
  logic [AW-1:0]  k_q, k_d;
  logic [AW-1:0]  lin_q, lin_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic           ena_q;
  logic [WID-1:0] dout_q;

  // Write side: accept a sync only into an EMPTY bank, otherwise flag overflow.
  always_comb begin
    w_state_d = w_state_q;
    wb_d      = wb_q;
    wr_cnt_d  = wr_cnt_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    wr_addr   = wr_cnt_q;
    set_full  = 2'b00;
    if (bidin_ena_in) begin
      if (bidin_sync_in) begin
        if (!full_q[wb_q]) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          wr_cnt_d  = AW'(1);
          w_state_d = W_FILL;
        end else begin
          ovf_d     = 1'b1;
          w_state_d = W_IDLE;
        end
      end else if (w_state_q == W_FILL) begin
        wr_en = 1'b1;
        if (wr_cnt_q == LAST_ADDR) begin
          set_full[wb_q] = 1'b1;
          wb_d           = ~wb_q;
          wr_cnt_d       = '0;
          w_state_d      = W_IDLE;
        end else begin
          wr_cnt_d = wr_cnt_q + AW'(1);
        end
      end
    end
  end

  // Read side: lin tracks row*COLS+col incrementally so no multiplier is needed.
  always_comb begin
    r_state_d = r_state_q;
    rb_d      = rb_q;
    mode_d    = mode_q;
    k_d       = k_q;
    lin_d     = lin_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_en     = 1'b0;
    clr_full  = 2'b00;
    case (r_state_q)
      R_IDLE: begin
        if (ldpc_req && full_q[rb_q]) begin
          mode_d    = bidin_mode;
          r_state_d = R_READ;
          k_d       = '0;
          lin_d     = '0;
          row_d     = '0;
          col_d     = '0;
        end
      end
      R_READ: begin
        rd_en = 1'b1;
        if (k_q == LAST_ADDR) begin
          r_state_d = R_DONE;
          k_d       = '0;
          lin_d     = '0;
          row_d     = '0;
          col_d     = '0;
        end else begin
          k_d = k_q + AW'(1);
          if (row_q == LAST_ROW) begin
            row_d = '0;
            col_d = col_q + CW'(1);
            lin_d = AW'(col_q) + AW'(1);
          end else begin
            row_d = row_q + RW'(1);
            lin_d = lin_q + AW'(COLS);
          end
        end
      end
      R_DONE: begin
        if (ldpc_fin) begin
          clr_full[rb_q] = 1'b1;
          rb_d           = ~rb_q;
          r_state_d      = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign rd_addr = mode_q ? k_q : lin_q;
  assign full_d  = (full_q & ~clr_full) | set_full;

  always_ff @(posedge clk6) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      wb_q      <= 1'b0;
      wr_cnt_q  <= '0;
      full_q    <= 2'b00;
      ovf_q     <= 1'b0;
      r_state_q <= R_IDLE;
      rb_q      <= 1'b0;
      mode_q    <= 1'b0;
      k_q       <= '0;
      lin_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ena_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      wb_q      <= wb_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      r_state_q <= r_state_d;
      rb_q      <= rb_d;
      mode_q    <= mode_d;
      k_q       <= k_d;
      lin_q     <= lin_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ena_q     <= rd_en;
      dout_q    <= rd_en ? mem_q[rb_q][rd_addr] : '0;
    end
  end

  // Sample storage has no reset; contents are don't-care until written.
  always_ff @(posedge clk6) begin
    if (wr_en && !rst) begin
      mem_q[wb_q][wr_addr] <= bidin_din;
    end
  end

  assign bidin_rdy     = (r_state_q == R_IDLE) && full_q[rb_q];
  assign bidin_full    = &full_q;
  assign bidin_ovf     = ovf_q;
  assign bidin_ena_out = ena_q;
  assign bidin_dout    = dout_q;

endmodule

// File: tb/tb_bidin_pp.sv
// Bench for bidin_pp (ROWS=3, COLS=4): a FIFO-of-blocks model predicts flags and
// the deinterleaved / linear output order from index arithmetic.
module tb_bidin_pp;

  localparam int WID  = 6;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic           clk6 = 1'b0;
  logic           rst;
  logic           bidin_sync_in, bidin_ena_in, bidin_mode, ldpc_req, ldpc_fin;
  logic [WID-1:0] bidin_din;
  logic           bidin_rdy, bidin_full, bidin_ovf, bidin_ena_out;
  logic [WID-1:0] bidin_dout;

  int total = 0;
  int bad   = 0;

  // Model: completed blocks in arrival order, the block being collected, overflow flag.
  logic [WID-1:0] fifo[$];
  logic [WID-1:0] cur[$];
  bit             collecting = 1'b0;
  bit             m_ovf = 1'b0;

  bidin_pp #(.WID(WID), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk6(clk6), .rst(rst),
    .bidin_sync_in(bidin_sync_in), .bidin_ena_in(bidin_ena_in), .bidin_din(bidin_din),
    .bidin_mode(bidin_mode), .ldpc_req(ldpc_req), .ldpc_fin(ldpc_fin),
    .bidin_rdy(bidin_rdy), .bidin_full(bidin_full), .bidin_ovf(bidin_ovf),
    .bidin_ena_out(bidin_ena_out), .bidin_dout(bidin_dout)
  );

  always #5 clk6 = ~clk6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One input cycle; model tracks what the block store should accept.
  task automatic drive(input bit s, input bit e, input logic [WID-1:0] d);
    bidin_sync_in = s;
    bidin_ena_in  = e;
    bidin_din     = d;
    if (e) begin
      if (s) begin
        if (fifo.size() == 2 * N) begin
          m_ovf      = 1'b1;
          collecting = 1'b0;
        end else begin
          cur.delete();
          cur.push_back(d);
          collecting = 1'b1;
        end
      end else if (collecting) begin
        cur.push_back(d);
      end
      if (collecting && cur.size() == N) begin
        for (int i = 0; i < N; i++) fifo.push_back(cur[i]);
        cur.delete();
        collecting = 1'b0;
      end
    end
    @(negedge clk6);
    bidin_sync_in = 1'b0;
    bidin_ena_in  = 1'b0;
  endtask

  task automatic write_blk(input int base, input bit rnd, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        drive(1'($urandom_range(0, 1)), 1'b0, WID'($urandom));
      drive(i == 0, 1'b1, rnd ? WID'($urandom) : WID'(base + i));
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_full"}, 32'(bidin_full), 32'(fifo.size() == 2 * N));
    chk({tag, "_ovf"},  32'(bidin_ovf),  32'(m_ovf));
    chk({tag, "_rdy"},  32'(bidin_rdy),  32'(fifo.size() != 0));
  endtask

  task automatic read_blk(input bit mode, input string tag);
    logic [WID-1:0] e [N];
    for (int k = 0; k < N; k++)
      e[k] = fifo[mode ? k : (k % ROWS) * COLS + k / ROWS];
    chk({tag, "_rdy_pre"}, 32'(bidin_rdy), 32'd1);
    ldpc_req   = 1'b1;
    bidin_mode = mode;
    @(negedge clk6);
    ldpc_req   = 1'b0;
    bidin_mode = 1'($urandom_range(0, 1));
    chk({tag, "_rdy_t1"}, 32'(bidin_rdy), 32'd0);
    chk({tag, "_ena_t1"}, 32'(bidin_ena_out), 32'd0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk6);
      chk($sformatf("%s_ena%0d", tag, k), 32'(bidin_ena_out), 32'd1);
      chk($sformatf("%s_dout%0d", tag, k), 32'(bidin_dout), 32'(e[k]));
    end
    @(negedge clk6);
    chk({tag, "_ena_end"}, 32'(bidin_ena_out), 32'd0);
    chk({tag, "_dout_end"}, 32'(bidin_dout), 32'd0);
    chk({tag, "_rdy_done"}, 32'(bidin_rdy), 32'd0);
    ldpc_fin = 1'b1;
    @(negedge clk6);
    ldpc_fin = 1'b0;
    for (int k = 0; k < N; k++) void'(fifo.pop_front());
    chk_flags({tag, "_post"});
  endtask

  initial begin
    rst = 1'b1;
    bidin_sync_in = 1'b0; bidin_ena_in = 1'b0; bidin_din = '0;
    bidin_mode = 1'b0; ldpc_req = 1'b0; ldpc_fin = 1'b0;
    @(negedge clk6);
    @(negedge clk6);
    chk("rst_rdy",  32'(bidin_rdy), 32'd0);
    chk("rst_full", 32'(bidin_full), 32'd0);
    chk("rst_ovf",  32'(bidin_ovf), 32'd0);
    chk("rst_ena",  32'(bidin_ena_out), 32'd0);
    chk("rst_dout", 32'(bidin_dout), 32'd0);
    rst = 1'b0;

    // Samples without a preceding sync are ignored; fin/req while idle are ignored.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, WID'(40 + i));
    ldpc_fin = 1'b1; ldpc_req = 1'b1;
    @(negedge clk6);
    ldpc_fin = 1'b0; ldpc_req = 1'b0;
    chk_flags("stray");

    // Column-major deinterleave, then linear pass-through of the same data.
    write_blk(0, 1'b0, 1'b0);
    chk_flags("m0_fill");
    read_blk(1'b0, "m0");
    write_blk(0, 1'b0, 1'b0);
    read_blk(1'b1, "m1");

    // Both banks full, third block dropped; overflow stays sticky.
    write_blk(0, 1'b1, 1'b1);
    write_blk(0, 1'b1, 1'b0);
    chk_flags("two_full");
    write_blk(50, 1'b0, 1'b0);
    chk_flags("ovf");
    read_blk(1'($urandom_range(0, 1)), "ovf_r1");
    read_blk(1'($urandom_range(0, 1)), "ovf_r2");

    // Partial block abandoned by a new sync.
    for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, WID'(i));
    write_blk(20, 1'b0, 1'b0);
    read_blk(1'b1, "restart");

    // Random traffic: abandoned prefixes, input gaps, random read modes.
    for (int it = 0; it < 6; it++) begin
      int p = $urandom_range(0, N - 1);
      for (int i = 0; i < p; i++) drive(i == 0, 1'b1, WID'($urandom));
      write_blk(0, 1'b1, 1'b1);
      if (it % 2 == 1) write_blk(0, 1'b1, 1'b1);
      while (fifo.size() != 0) read_blk(1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
    end

    // Reset in the middle of a read aborts it; next block lands in bank 0.
    write_blk(0, 1'b1, 1'b0);
    ldpc_req = 1'b1; bidin_mode = 1'b0;
    @(negedge clk6);
    ldpc_req = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk6);
    chk("mid_ena4", 32'(bidin_ena_out), 32'd1);
    rst = 1'b1;
    @(negedge clk6);
    chk("mid_rst_ena",  32'(bidin_ena_out), 32'd0);
    chk("mid_rst_dout", 32'(bidin_dout), 32'd0);
    chk("mid_rst_rdy",  32'(bidin_rdy), 32'd0);
    chk("mid_rst_full", 32'(bidin_full), 32'd0);
    chk("mid_rst_ovf",  32'(bidin_ovf), 32'd0);
    rst = 1'b0;
    fifo.delete(); cur.delete(); collecting = 1'b0; m_ovf = 1'b0;
    write_blk(0, 1'b1, 1'b0);
    chk_flags("after_rst");
    read_blk(1'b1, "after_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
